// File: rtl/stream_buffer_arbiter_if.sv
// Handshake bundle between the stream-buffer FIFOs, the arbiter and the readout path.
// master = arbiter side, slave = FIFO bank / downstream side.
interface stream_buffer_arbiter_if #(
    parameter int N_CH = 4
);
    localparam int CW = $clog2(N_CH);

    logic                      en;
    logic [N_CH-1:0]           fifo_empty;
    logic [N_CH-1:0][39:0]     fifo_data;
    logic [N_CH-1:0]           fifo_rd_en;
    logic [39:0]               dout;
    logic [CW-1:0]             dout_ch;
    logic                      dout_valid;
    logic                      dout_ready;
    logic                      busy;
    logic [CW-1:0]             grant;

    modport master (
        input  en, fifo_empty, fifo_data, dout_ready,
        output fifo_rd_en, dout, dout_ch, dout_valid, busy, grant
    );

    modport slave (
        output en, fifo_empty, fifo_data, dout_ready,
        input  fifo_rd_en, dout, dout_ch, dout_valid, busy, grant
    );
endinterface

// File: rtl/stream_buffer_arbiter.sv
// Round-robin burst reader: drains up to MAX_BURST words from one FIFO per grant
// into a registered valid/ready output stage tagged with the source channel.

module stream_buffer_arbiter_lane (
    input  logic sel,
    input  logic rd_ok,
    input  logic empty,
    output logic rd_en
);
    assign rd_en = sel & rd_ok & ~empty;
endmodule

module stream_buffer_arbiter #(
    parameter int N_CH      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    stream_buffer_arbiter_if.master bus
);
    localparam int CW = $clog2(N_CH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   grant, grant_nx, last, last_nx, pick;
    logic [3:0]      burst_cnt, cnt_nx;
    logic [39:0]     dout;
    logic [CW-1:0]   dout_ch;
    logic            dout_valid;
    logic            have_req, load_ok, rd_ok, rd, grant_empty;
    logic [N_CH-1:0] rd_en;

    // Walk downwards so the nearest non-empty channel after 'last' wins.
    always_comb begin
        pick = last;
        for (int k = N_CH; k >= 1; k--) begin
            if (!bus.fifo_empty[CW'(last + CW'(k))])
                pick = CW'(last + CW'(k));
        end
    end

    assign have_req    = bus.en & ~(&bus.fifo_empty);
    assign load_ok     = ~dout_valid | bus.dout_ready;
    assign grant_empty = bus.fifo_empty[grant];
    assign rd_ok       = (state == BURST) & load_ok & (burst_cnt < 4'(MAX_BURST));

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        stream_buffer_arbiter_lane u_lane (
            .sel   (grant == CW'(i)),
            .rd_ok (rd_ok),
            .empty (bus.fifo_empty[i]),
            .rd_en (rd_en[i])
        );
    end

    assign rd = |rd_en;

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        cnt_nx   = burst_cnt;
        case (state)
            IDLE: begin
                if (have_req) begin
                    state_nx = BURST;
                    grant_nx = pick;
                    last_nx  = pick;
                    cnt_nx   = '0;
                end
            end
            BURST: begin
                if (rd) begin
                    cnt_nx = burst_cnt + 4'd1;
                    if (burst_cnt == 4'(MAX_BURST - 1))
                        state_nx = IDLE;
                end else if (grant_empty) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= CW'(N_CH - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            last      <= last_nx;
            burst_cnt <= cnt_nx;
        end
    end

    // Output stage: a read always refills it; an accepted word with no refill empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
        end else if (rd) begin
            dout       <= bus.fifo_data[grant];
            dout_ch    <= grant;
            dout_valid <= 1'b1;
        end else if (bus.dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.dout       = dout;
    assign bus.dout_ch    = dout_ch;
    assign bus.dout_valid = dout_valid;
    assign bus.busy       = (state == BURST);
    assign bus.grant      = grant;
endmodule

// File: tb/tb_stream_buffer_arbiter.sv
// Bench for stream_buffer_arbiter: FWFT FIFO models plus a transaction-level
// round-robin predictor of the accepted output word sequence.
module tb_stream_buffer_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    typedef logic [39:0] word_t;
    typedef struct packed {
        logic [1:0] ch;
        word_t      w;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stream_buffer_arbiter_if #(.N_CH(N)) bus ();
    stream_buffer_arbiter #(.N_CH(N), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    word_t      fq [N][$];
    exp_t       expq[$];
    int         bch[$], blen[$];
    int         trace[$], et[$];
    int         n_assert = 0, n_fail = 0;
    int         model_last = N - 1;
    int         wid = 0;
    bit         rand_rdy = 0, rec = 0;
    logic [N-1:0] rd_lat;
    logic       acc_lat, stall_lat;
    word_t      dout_lat;
    logic [1:0] ch_lat;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rd_index(logic [N-1:0] v);
        rd_index = -1;
        for (int i = 0; i < N; i++) if (v[i]) rd_index = i;
    endfunction

    task automatic update_ifc();
        for (int i = 0; i < N; i++) begin
            bus.fifo_empty[i] = (fq[i].size() == 0);
            bus.fifo_data[i]  = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic latch();
        rd_lat    = bus.fifo_rd_en;
        acc_lat   = bus.dout_valid & bus.dout_ready;
        stall_lat = bus.dout_valid & ~bus.dout_ready;
        dout_lat  = bus.dout;
        ch_lat    = bus.dout_ch;
    endtask

    task automatic settle();
        update_ifc();
        #1;
        latch();
    endtask

    task automatic load(int ch, int n);
        for (int j = 0; j < n; j++) begin
            fq[ch].push_back({8'(ch), 8'(wid), 24'($urandom)});
            wid++;
        end
    endtask

    // Round-robin from the last grant; each grant takes min(MB, remaining) words.
    task automatic predict();
        int rem[N];
        int pos[N];
        int found, b;
        for (int i = 0; i < N; i++) begin rem[i] = fq[i].size(); pos[i] = 0; end
        bch.delete(); blen.delete();
        while (1) begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (model_last + k) % N;
                if (found < 0 && rem[c] > 0) found = c;
            end
            if (found < 0) break;
            b = (rem[found] < MB) ? rem[found] : MB;
            for (int j = 0; j < b; j++)
                expq.push_back({2'(found), fq[found][pos[found] + j]});
            pos[found] += b;
            rem[found] -= b;
            model_last = found;
            bch.push_back(found);
            blen.push_back(b);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (acc_lat) begin
            chk("exp_avail", 64'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("dout_ch", 64'(ch_lat), 64'(e.ch));
                chk("dout", 64'(dout_lat), 64'(e.w));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rd_lat[i]) begin
                chk("rd_nonempty", 64'(fq[i].size() != 0), 1);
                if (fq[i].size() != 0) void'(fq[i].pop_front());
            end
        end
        if (rand_rdy) bus.dout_ready = ($urandom_range(0, 9) < 7);
        update_ifc();
        @(negedge clk);
        chk("rd_onehot0", 64'($onehot0(bus.fifo_rd_en)), 1);
        chk("rd_vs_empty", 64'(bus.fifo_rd_en & bus.fifo_empty), 0);
        if (stall_lat) begin
            chk("stall_valid", 64'(bus.dout_valid), 1);
            chk("stall_dout", 64'(bus.dout), 64'(dout_lat));
            chk("stall_ch", 64'(bus.dout_ch), 64'(ch_lat));
        end
        if (bus.dout_valid && !bus.dout_ready) chk("rd_while_stalled", 64'(bus.fifo_rd_en), 0);
        if (rec) trace.push_back(rd_index(bus.fifo_rd_en));
        latch();
    endtask

    task automatic drain(int budget);
        int c = 0;
        while ((expq.size() != 0 || bus.busy || bus.dout_valid) && c < budget) begin
            step();
            c++;
        end
        chk("drain_in_budget", 64'(c < budget), 1);
        chk("drain_all_words", 64'(expq.size()), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        latch();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
        model_last = N - 1;
        settle();
    endtask

    initial begin
        bit eb[6], er[6], ev[6];
        reset = 1'b1;
        bus.en = 1'b1;
        bus.dout_ready = 1'b1;
        update_ifc();

        // reset state
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_valid", 64'(bus.dout_valid), 0);
        chk("rst_rd_en", 64'(bus.fifo_rd_en), 0);
        chk("rst_dout", 64'(bus.dout), 0);
        chk("rst_dout_ch", 64'(bus.dout_ch), 0);
        chk("rst_grant", 64'(bus.grant), 0);
        @(negedge clk);
        reset = 1'b0;
        settle();

        // three words in channel 0: cycle-exact busy / rd_en / valid
        eb = '{0, 1, 1, 1, 1, 0};
        er = '{0, 1, 1, 1, 0, 0};
        ev = '{0, 0, 1, 1, 1, 0};
        load(0, 3); predict(); settle();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            chk("t1_busy", 64'(bus.busy), 64'(eb[c]));
            chk("t1_rd_en", 64'(bus.fifo_rd_en), 64'(er[c]));
            chk("t1_valid", 64'(bus.dout_valid), 64'(ev[c]));
        end
        drain(50);

        // all channels 6 words: grant order, burst lengths and gaps from the read trace
        do_reset();
        for (int i = 0; i < N; i++) load(i, 6);
        predict(); settle();
        trace.delete(); rec = 1;
        trace.push_back(rd_index(bus.fifo_rd_en));
        drain(200);
        rec = 0;
        et.delete();
        et.push_back(-1);
        for (int b = 0; b < bch.size(); b++) begin
            for (int j = 0; j < blen[b]; j++) et.push_back(bch[b]);
            if (b != bch.size() - 1)
                for (int g = 0; g < ((blen[b] == MB) ? 1 : 2); g++) et.push_back(-1);
        end
        chk("t2_trace_len", 64'(trace.size() >= et.size()), 1);
        for (int i = 0; i < et.size() && i < trace.size(); i++)
            chk("t2_trace", 64'(trace[i]), 64'(et[i]));

        // 5-cycle downstream stall mid-burst
        do_reset();
        load(0, 4); predict(); settle();
        step(); step(); step();
        bus.dout_ready = 1'b0; settle();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_rd_stalled", 64'(bus.fifo_rd_en), 0);
            chk("t3_busy", 64'(bus.busy), 1);
        end
        bus.dout_ready = 1'b1; settle();
        chk("t3_resume_rd0", 64'(bus.fifo_rd_en), 1);
        step();
        chk("t3_resume_rd1", 64'(bus.fifo_rd_en), 1);
        step();
        chk("t3_burst_done", 64'(bus.busy), 0);
        drain(50);

        // last=1, channels 1 and 3 pending: 3 goes first
        do_reset();
        load(1, 1); predict(); settle(); drain(50);
        load(1, 2); load(3, 2); predict(); settle();
        step();
        chk("t4_busy", 64'(bus.busy), 1);
        chk("t4_grant", 64'(bus.grant), 3);
        drain(100);

        // en dropped during a burst on channel 2
        do_reset();
        load(1, 1); predict(); settle(); drain(50);
        load(2, 6); load(3, 2); load(0, 2); predict(); settle();
        step();
        chk("t5_grant2", 64'(bus.grant), 2);
        bus.en = 1'b0; settle();
        for (int c = 0; c < 20 && bus.busy; c++) step();
        chk("t5_left_in_ch2", 64'(fq[2].size()), 2);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("t5_idle_busy", 64'(bus.busy), 0);
            chk("t5_idle_rd", 64'(bus.fifo_rd_en), 0);
        end
        bus.en = 1'b1; settle();
        step();
        chk("t5_next_busy", 64'(bus.busy), 1);
        chk("t5_next_grant", 64'(bus.grant), 3);
        drain(100);

        // asynchronous reset mid-burst
        do_reset();
        load(1, 4); load(2, 3); predict(); settle();
        step(); step(); step();
        reset = 1'b1;
        #1;
        chk("t6_valid", 64'(bus.dout_valid), 0);
        chk("t6_busy", 64'(bus.busy), 0);
        chk("t6_rd_en", 64'(bus.fifo_rd_en), 0);
        latch();
        expq.delete();
        model_last = N - 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        predict(); settle();
        step();
        chk("t6_regrant_busy", 64'(bus.busy), 1);
        chk("t6_regrant_ch", 64'(bus.grant), 1);
        drain(100);

        // randomized contents and backpressure
        for (int r = 0; r < 8; r++) begin
            rand_rdy = 1;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) != 0) load(i, $urandom_range(1, 8));
            predict(); settle();
            drain(500);
            rand_rdy = 0;
            bus.dout_ready = 1'b1;
            settle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
